// File: rtl/uart_fifo_core_pkg.sv
// uart_fifo_core_pkg: shared FSM state encoding and default constants for the
// serial port core and its FIFO buffers.
package uart_fifo_core_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned DBIT_DEF    = 8;
   localparam int unsigned SB_TICK_DEF = 16;
   localparam int unsigned DVSR_DEF    = 326;
   localparam int unsigned FIFO_W_DEF  = 10;

   // oversampling ticks per data bit
   localparam int unsigned OS_RATE     = 16;

   // counter width able to hold 0..n-1 (at least 1 bit)
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_fifo_core_fifo_buf.sv
// fifo_buf: circular buffer with registered full/empty flags and show-ahead
// read data. Storage is not reset; only pointers and flags are.
module fifo_buf
   import uart_fifo_core_pkg::*;
#(
   parameter int unsigned B = 8,
   parameter int unsigned W = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_rd,
   input  logic         i_wr,
   input  logic [B-1:0] i_w_data,
   output logic         o_empty,
   output logic         o_full,
   output logic [B-1:0] o_r_data
);

   localparam int unsigned DEPTH = 1 << W;

   logic [B-1:0] mem [DEPTH];
   logic [W-1:0] w_ptr;
   logic [W-1:0] r_ptr;
   logic         full_q;
   logic         empty_q;
   logic         wr_en_c;
   logic         rd_en_c;

   // a write while full is accepted only when a read frees the slot in the same cycle
   assign wr_en_c  = i_wr && (!full_q || i_rd);
   assign rd_en_c  = i_rd && !empty_q;
   assign o_r_data = mem[r_ptr];
   assign o_empty  = empty_q;
   assign o_full   = full_q;

   // storage write port
   always_ff @(posedge i_clk) begin
      if (wr_en_c) mem[w_ptr] <= i_w_data;
   end

   // pointer and flag update
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         w_ptr   <= '0;
         r_ptr   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         case ({wr_en_c, rd_en_c})
            2'b01: begin
               r_ptr  <= r_ptr + W'(1);
               full_q <= 1'b0;
               if (r_ptr + W'(1) == w_ptr) empty_q <= 1'b1;
            end
            2'b10: begin
               w_ptr   <= w_ptr + W'(1);
               empty_q <= 1'b0;
               if (w_ptr + W'(1) == r_ptr) full_q <= 1'b1;
            end
            2'b11: begin
               w_ptr <= w_ptr + W'(1);
               r_ptr <= r_ptr + W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex 8N1 UART with 16x oversampling, shared baud
// tick, and one FIFO per direction.
// Optional: define UART_FRAMING_CHECK_EN to drop received bytes whose stop
// bit samples low at mid-stop.
module uart_fifo_core
   import uart_fifo_core_pkg::*;
#(
   parameter int unsigned DBIT    = DBIT_DEF,
   parameter int unsigned SB_TICK = SB_TICK_DEF,
   parameter int unsigned DVSR    = DVSR_DEF,
   parameter int unsigned FIFO_W  = FIFO_W_DEF
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_rd_uart,
   input  logic            i_wr_uart,
   input  logic            i_rx,
   input  logic [DBIT-1:0] i_w_data,
   output logic            o_tx_full,
   output logic            o_rx_empty,
   output logic            o_tx,
   output logic [DBIT-1:0] o_r_data
);

   localparam int unsigned DW = cnt_w(DVSR);
   localparam int unsigned SW = cnt_w((SB_TICK > OS_RATE) ? SB_TICK : OS_RATE);
   localparam int unsigned NW = cnt_w(DBIT);

   logic [DW-1:0]   baud_cnt;
   logic            baud_tick_c;

   logic [1:0]      rx_sync;
   logic            rx_s;
   uart_state_e     rx_state;
   logic [SW-1:0]   rx_s_cnt;
   logic [NW-1:0]   rx_n_cnt;
   logic [DBIT-1:0] rx_byte;
   logic            rx_stop_end_c;
   logic            rx_push_c;
   logic            rx_full;

   uart_state_e     tx_state;
   logic [SW-1:0]   tx_s_cnt;
   logic [NW-1:0]   tx_n_cnt;
   logic [DBIT-1:0] tx_b;
   logic            tx_reg;
   logic            tx_pop_c;
   logic            tx_empty;
   logic [DBIT-1:0] tx_head;

   assign baud_tick_c = (baud_cnt == DW'(DVSR - 1));

   // free-running oversampling tick generator
   always_ff @(posedge i_clk) begin
      if (i_reset)          baud_cnt <= '0;
      else if (baud_tick_c) baud_cnt <= '0;
      else                  baud_cnt <= baud_cnt + DW'(1);
   end

   // two-flop synchronizer for the asynchronous serial input
   always_ff @(posedge i_clk) begin
      if (i_reset) rx_sync <= 2'b11;
      else         rx_sync <= {rx_sync[0], i_rx};
   end
   assign rx_s = rx_sync[1];

   assign rx_stop_end_c = (rx_state == STOP) && baud_tick_c &&
                          (rx_s_cnt == SW'(SB_TICK - 1));

`ifdef UART_FRAMING_CHECK_EN
   logic rx_stop_ok;

   // stop-bit level captured mid-stop; a low stop bit discards the byte
   always_ff @(posedge i_clk) begin
      if (i_reset) rx_stop_ok <= 1'b1;
      else if ((rx_state == STOP) && baud_tick_c && (rx_s_cnt == SW'(SB_TICK / 2)))
         rx_stop_ok <= rx_s;
   end
   assign rx_push_c = rx_stop_end_c && rx_stop_ok && !rx_full;
`else
   assign rx_push_c = rx_stop_end_c && !rx_full;
`endif

   // receiver: start-bit validation, mid-bit sampling, stop-bit wait
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rx_state <= IDLE;
         rx_s_cnt <= '0;
         rx_n_cnt <= '0;
         rx_byte  <= '0;
      end else begin
         case (rx_state)
            IDLE: if (!rx_s) begin
               rx_state <= START;
               rx_s_cnt <= '0;
            end
            START: if (baud_tick_c) begin
               if (rx_s_cnt == SW'(OS_RATE / 2 - 1)) begin
                  rx_s_cnt <= '0;
                  rx_n_cnt <= '0;
                  rx_state <= rx_s ? IDLE : DATA;
               end else rx_s_cnt <= rx_s_cnt + SW'(1);
            end
            DATA: if (baud_tick_c) begin
               if (rx_s_cnt == SW'(OS_RATE - 1)) begin
                  rx_s_cnt <= '0;
                  rx_byte  <= {rx_s, rx_byte[DBIT-1:1]};
                  if (rx_n_cnt == NW'(DBIT - 1)) rx_state <= STOP;
                  else                           rx_n_cnt <= rx_n_cnt + NW'(1);
               end else rx_s_cnt <= rx_s_cnt + SW'(1);
            end
            STOP: if (baud_tick_c) begin
               if (rx_s_cnt == SW'(SB_TICK - 1)) rx_state <= IDLE;
               else                              rx_s_cnt <= rx_s_cnt + SW'(1);
            end
            default: rx_state <= IDLE;
         endcase
      end
   end

   assign tx_pop_c = (tx_state == STOP) && baud_tick_c &&
                     (tx_s_cnt == SW'(SB_TICK - 1));

   // transmitter: serializes the TX FIFO head, popping it at end of stop bit
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tx_state <= IDLE;
         tx_s_cnt <= '0;
         tx_n_cnt <= '0;
         tx_b     <= '0;
         tx_reg   <= 1'b1;
      end else begin
         case (tx_state)
            IDLE: begin
               tx_reg <= 1'b1;
               if (!tx_empty) begin
                  tx_state <= START;
                  tx_s_cnt <= '0;
                  tx_b     <= tx_head;
                  tx_reg   <= 1'b0;
               end
            end
            START: if (baud_tick_c) begin
               if (tx_s_cnt == SW'(OS_RATE - 1)) begin
                  tx_state <= DATA;
                  tx_s_cnt <= '0;
                  tx_n_cnt <= '0;
                  tx_reg   <= tx_b[0];
               end else tx_s_cnt <= tx_s_cnt + SW'(1);
            end
            DATA: if (baud_tick_c) begin
               if (tx_s_cnt == SW'(OS_RATE - 1)) begin
                  tx_s_cnt <= '0;
                  tx_b     <= {1'b0, tx_b[DBIT-1:1]};
                  if (tx_n_cnt == NW'(DBIT - 1)) begin
                     tx_state <= STOP;
                     tx_reg   <= 1'b1;
                  end else begin
                     tx_n_cnt <= tx_n_cnt + NW'(1);
                     tx_reg   <= tx_b[1];
                  end
               end else tx_s_cnt <= tx_s_cnt + SW'(1);
            end
            STOP: if (baud_tick_c) begin
               if (tx_s_cnt == SW'(SB_TICK - 1)) tx_state <= IDLE;
               else                              tx_s_cnt <= tx_s_cnt + SW'(1);
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

   assign o_tx = tx_reg;

   fifo_buf #(.B(DBIT), .W(FIFO_W)) u_rx_fifo (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_rd     (i_rd_uart),
      .i_wr     (rx_push_c),
      .i_w_data (rx_byte),
      .o_empty  (o_rx_empty),
      .o_full   (rx_full),
      .o_r_data (o_r_data)
   );

   fifo_buf #(.B(DBIT), .W(FIFO_W)) u_tx_fifo (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_rd     (tx_pop_c),
      .i_wr     (i_wr_uart),
      .i_w_data (i_w_data),
      .o_empty  (tx_empty),
      .o_full   (o_tx_full),
      .o_r_data (tx_head)
   );

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: scoreboard bench for uart_fifo_core with a reduced
// divider and FIFO depth; loopback or bench-driven serial input.
module tb_uart_fifo_core;

   localparam int unsigned DVSR_T     = 4;
   localparam int unsigned FIFO_W_T   = 3;
   localparam int unsigned DEPTH      = 1 << FIFO_W_T;
   localparam int unsigned BIT_CLKS   = 16 * DVSR_T;
   localparam int unsigned FRAME_CLKS = 10 * BIT_CLKS;

   logic       clk = 1'b0;
   logic       rst;
   logic       rd;
   logic       wr;
   logic       drv_rx;
   logic       loop_en;
   logic       rx_line;
   logic       tx;
   logic       tx_full;
   logic       rx_empty;
   logic [7:0] w_data;
   logic [7:0] r_data;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] burst [11] = '{8'hFE, 8'h02, 8'h02, 8'h20, 8'h02, 8'h00,
                              8'h3F, 8'h00, 8'h00, 8'h00, 8'hF0};

   always #5 clk = ~clk;

   assign rx_line = loop_en ? tx : drv_rx;

   uart_fifo_core #(
      .DBIT(8), .SB_TICK(16), .DVSR(DVSR_T), .FIFO_W(FIFO_W_T)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_rd_uart  (rd),
      .i_wr_uart  (wr),
      .i_rx       (rx_line),
      .i_w_data   (w_data),
      .o_tx_full  (tx_full),
      .o_rx_empty (rx_empty),
      .o_tx       (tx),
      .o_r_data   (r_data)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // monitor: pops every received byte and compares it with the scoreboard
   initial begin
      rd = 1'b0;
      forever begin
         @(negedge clk);
         rd = 1'b0;
         if (rst === 1'b0 && rx_empty === 1'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rx_unexpected: got %02h expected no byte", r_data);
            end else begin
               check("rx_byte", r_data, exp_q.pop_front());
            end
            rd = 1'b1;
         end
      end
   end

   task automatic push(input logic [7:0] b, input bit wait_space, input bit expect_rx);
      int n = 0;
      if (wait_space) begin
         while (tx_full === 1'b1 && n < 4 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
         end
         if (tx_full !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL tx_space_timeout: tx_full %b expected 0", tx_full);
         end
      end
      wr     = 1'b1;
      w_data = b;
      if (expect_rx) exp_q.push_back(b);
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: %0d bytes pending expected 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (2 * BIT_CLKS) @(negedge clk);
      check({name, "_rx_empty"}, 8'(rx_empty), 8'h01);
   endtask

   // bench-driven frame; stop_low holds the stop bit low for its first 10 ticks
   task automatic send_frame(input logic [7:0] b, input bit stop_low);
      drv_rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drv_rx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      if (stop_low) begin
         drv_rx = 1'b0;
         repeat (10 * DVSR_T) @(negedge clk);
      end
      drv_rx = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      wr      = 1'b0;
      w_data  = '0;
      drv_rx  = 1'b1;
      loop_en = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_tx", 8'(tx), 8'h01);
      check("reset_tx_full", 8'(tx_full), 8'h00);
      check("reset_rx_empty", 8'(rx_empty), 8'h01);
      rst = 1'b0;
      @(negedge clk);

      // single loopback byte
      push(8'hFE, 1'b1, 1'b1);
      drain("single", 2 * FRAME_CLKS);

      // back-to-back burst larger than the TX FIFO
      for (int i = 0; i < 11; i++) push(burst[i], 1'b1, 1'b1);
      drain("burst", 14 * FRAME_CLKS);

      // fill TX FIFO, then one extra write that must be dropped
      for (int i = 0; i < DEPTH; i++) push(8'(8'hA0 + i), 1'b0, 1'b1);
      check("tx_full_set", 8'(tx_full), 8'h01);
      push(8'hEE, 1'b0, 1'b0);
      check("tx_full_hold", 8'(tx_full), 8'h01);
      drain("full", (DEPTH + 2) * FRAME_CLKS);
      check("tx_full_clear", 8'(tx_full), 8'h00);

      // reset during a frame: line returns high, queued data lost
      push(8'h5A, 1'b1, 1'b0);
      repeat (220) @(negedge clk);
      check("tx_low_mid_frame", 8'(tx), 8'h00);
      rst = 1'b1;
      @(negedge clk);
      check("midreset_tx", 8'(tx), 8'h01);
      check("midreset_tx_full", 8'(tx_full), 8'h00);
      check("midreset_rx_empty", 8'(rx_empty), 8'h01);
      rst = 1'b0;
      repeat (2 * FRAME_CLKS) @(negedge clk);
      check("midreset_nothing_rx", 8'(rx_empty), 8'h01);

      // start-bit glitch shorter than half a bit
      loop_en = 1'b0;
      drv_rx  = 1'b0;
      repeat (3 * DVSR_T) @(negedge clk);
      drv_rx = 1'b1;
      repeat (FRAME_CLKS) @(negedge clk);
      check("glitch_rx_empty", 8'(rx_empty), 8'h01);

      // clean externally driven frame
      exp_q.push_back(8'hA7);
      send_frame(8'hA7, 1'b0);
      drain("ext", 2 * FRAME_CLKS);

      // bad stop bit
`ifndef UART_FRAMING_CHECK_EN
      exp_q.push_back(8'h55);
`endif
      send_frame(8'h55, 1'b1);
      drain("framing", 2 * FRAME_CLKS);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
